// File: rtl/sap1_fetch_pkg.sv
// sap1_fetch_pkg
// Shared definitions for the SAP-1 instruction fetch stage.
//   fetch_state_t : the five states of the fetch sequencer
//   PC_RESET      : program counter value after reset
package sap1_fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_INC  = 3'd1,
        FETCH_READ = 3'd2,
        DISPATCH   = 3'd3,
        HALTED     = 3'd4
    } fetch_state_t;

    localparam int PC_RESET = 0;

endpackage

// File: rtl/fetch_unit_program_counter.sv
// program_counter
// AddressSize-wide program counter for the SAP-1 fetch stage.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   inc         : advance the count by one, wrapping at 2^AddressSize
//   load        : replace the count with load_value (wins over inc)
//   load_value  : value to load
//   count       : current counter value
module program_counter
    import sap1_fetch_pkg::*;
#(
    parameter int AddressSize = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   load,
    input  logic [AddressSize-1:0] load_value,
    output logic [AddressSize-1:0] count
);

    logic [AddressSize-1:0] count_q;
    logic [AddressSize-1:0] count_d;

    // Load takes priority so a jump issued in the same cycle as an
    // increment request always lands on the target. The add wraps
    // naturally because the result is truncated to AddressSize bits.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (inc) begin
            count_d = count_q + AddressSize'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= AddressSize'(PC_RESET);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// SAP-1 instruction fetch stage in front of the 16x8 program ROM. Holds the
// PC (via program_counter), MAR and IR, drives the ROM address and active-low
// chip enable, and hands opcode/operand to execute with a valid/done handshake.
// Optional feature macro: FETCH_SINGLE_STEP_EN adds a 'step' input that gates
// each new fetch; when undefined, fetching free-runs.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   step               : (FETCH_SINGLE_STEP_EN only) allow the next fetch
//   rom_input_address  : ROM address, always the MAR
//   CE_bar             : ROM chip enable, low only during FETCH_READ
//   rom_output_data    : ROM read data
//   instr_valid        : IR holds an instruction awaiting execute
//   opcode, operand    : upper / lower fields of the IR
//   exec_done          : execute finished the current instruction
//   jump, jump_address : with exec_done, redirect the PC
//   halt               : with exec_done, stop fetching until reset
//   halted             : unit is parked in HALTED
//   pc                 : current program counter
module fetch_unit
    import sap1_fetch_pkg::*;
#(
    parameter int WordSize    = 8,
    parameter int AddressSize = 4,
    parameter int OpcodeSize  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic                           step,
`endif
    output logic [AddressSize-1:0]         rom_input_address,
    output logic                           CE_bar,
    input  logic [WordSize-1:0]            rom_output_data,
    output logic                           instr_valid,
    output logic [OpcodeSize-1:0]          opcode,
    output logic [WordSize-OpcodeSize-1:0] operand,
    input  logic                           exec_done,
    input  logic                           jump,
    input  logic [AddressSize-1:0]         jump_address,
    input  logic                           halt,
    output logic                           halted,
    output logic [AddressSize-1:0]         pc
);

    fetch_state_t           state_q, state_d;
    logic [AddressSize-1:0] mar_q, mar_d;
    logic [WordSize-1:0]    ir_q, ir_d;
    logic                   ce_bar_q, ce_bar_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;
    logic                   pc_inc;
    logic                   pc_load;
    logic                   advance;
    logic [AddressSize-1:0] pc_value;

    program_counter #(
        .AddressSize(AddressSize)
    ) u_program_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (jump_address),
        .count      (pc_value)
    );

`ifdef FETCH_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // Next-state logic. The handshake outputs are decoded from the next
    // state so they come straight out of flops and line up exactly with the
    // state they describe, with no path from any input to an output.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            FETCH_ADDR: begin
                if (advance) begin
                    mar_d   = pc_value;
                    state_d = FETCH_INC;
                end
            end
            FETCH_INC: begin
                pc_inc  = 1'b1;
                state_d = FETCH_READ;
            end
            FETCH_READ: begin
                ir_d    = rom_output_data;
                state_d = DISPATCH;
            end
            DISPATCH: begin
                // halt outranks jump; a halted PC keeps pointing past the
                // halting instruction.
                if (exec_done) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_load = jump;
                        state_d = FETCH_ADDR;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH_ADDR;
            end
        endcase
        ce_bar_d      = (state_d != FETCH_READ);
        instr_valid_d = (state_d == DISPATCH);
        halted_d      = (state_d == HALTED);
    end

    // Single state register for the sequencer and its registered outputs.
    // Reset is asynchronous so CE_bar releases immediately mid-read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_ADDR;
            mar_q         <= '0;
            ir_q          <= '0;
            ce_bar_q      <= 1'b1;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mar_q         <= mar_d;
            ir_q          <= ir_d;
            ce_bar_q      <= ce_bar_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign rom_input_address = mar_q;
    assign CE_bar            = ce_bar_q;
    assign instr_valid       = instr_valid_q;
    assign halted            = halted_q;
    assign opcode            = ir_q[WordSize-1 -: OpcodeSize];
    assign operand           = ir_q[WordSize-OpcodeSize-1:0];
    assign pc                = pc_value;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed testbench for fetch_unit with a behavioural 16x8 ROM.
// Works in both builds; the step scenario is only present when
// FETCH_SINGLE_STEP_EN is defined.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [3:0] rom_input_address;
    logic       CE_bar;
    logic [7:0] rom_output_data;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       exec_done;
    logic       jump;
    logic [3:0] jump_address;
    logic       halt;
    logic       halted;
    logic [3:0] pc;
`ifdef FETCH_SINGLE_STEP_EN
    logic       step;
`endif

    logic [7:0] rom [16];
    int         vector_count;
    int         miscompare_count;

    fetch_unit #(
        .WordSize    (8),
        .AddressSize (4),
        .OpcodeSize  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef FETCH_SINGLE_STEP_EN
        .step              (step),
`endif
        .rom_input_address (rom_input_address),
        .CE_bar            (CE_bar),
        .rom_output_data   (rom_output_data),
        .instr_valid       (instr_valid),
        .opcode            (opcode),
        .operand           (operand),
        .exec_done         (exec_done),
        .jump              (jump),
        .jump_address      (jump_address),
        .halt              (halt),
        .halted            (halted),
        .pc                (pc)
    );

    // ROM only drives real data while enabled, so a capture outside the
    // read cycle shows up as 0x00.
    assign rom_output_data = CE_bar ? 8'h00 : rom[rom_input_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the execute-side request lines, then advance one clock.
    task automatic applyStimulus(input logic done, input logic jmp,
                                 input logic [3:0] target, input logic hlt);
        exec_done    = done;
        jump         = jmp;
        jump_address = target;
        halt         = hlt;
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ce_bar"}, 32'(CE_bar), 32'h1);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'h0);
        checkOutput({tag, "_halted"}, 32'(halted), 32'h0);
        checkOutput({tag, "_pc"}, 32'(pc), 32'h0);
        checkOutput({tag, "_mar"}, 32'(rom_input_address), 32'h0);
        checkOutput({tag, "_opcode"}, 32'(opcode), 32'h0);
        checkOutput({tag, "_operand"}, 32'(operand), 32'h0);
    endtask

    logic [3:0] exp_op  [3];
    logic [3:0] exp_opd [3];
    int         valid_seen;

    initial begin
        vector_count     = 0;
        miscompare_count = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hA0 + 8'(i);
        rom[0] = 8'h1E;
        rom[1] = 8'h2F;
        rom[2] = 8'hF0;
        exp_op  = '{4'h1, 4'h2, 4'hF};
        exp_opd = '{4'hE, 4'hF, 4'h0};
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1;
`endif
        exec_done    = 1'b0;
        jump         = 1'b0;
        jump_address = 4'h0;
        halt         = 1'b0;

        // Reset state
        rst = 1'b1;
        #2;
        checkResetValues("reset");
        tick();
        rst = 1'b0;

        // Free-running fetch of rom[0..2] with exec_done tied high
        exec_done = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("run_valid_c%0d", c), 32'(instr_valid),
                        32'((c % 4) == 3));
            checkOutput($sformatf("run_ce_c%0d", c), 32'(CE_bar),
                        32'((c % 4) != 2));
            if ((c % 4) == 3) begin
                checkOutput($sformatf("run_opcode_c%0d", c), 32'(opcode),
                            32'(exp_op[c / 4]));
                checkOutput($sformatf("run_operand_c%0d", c), 32'(operand),
                            32'(exp_opd[c / 4]));
            end
        end
        checkOutput("run_pc", 32'(pc), 32'h3);

        // Fetch rom[3], hold in DISPATCH; jump without exec_done is ignored
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("hold_valid", 32'(instr_valid), 32'h1);
        checkOutput("hold_ir", 32'({opcode, operand}), 32'hA3);
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b0);
        checkOutput("nodone_valid", 32'(instr_valid), 32'h1);
        checkOutput("nodone_pc", 32'(pc), 32'h4);

        // Jump to 9: PC loads on the sampling edge, next read is rom[9]
        applyStimulus(1'b1, 1'b1, 4'h9, 1'b0);
        checkOutput("jump9_valid", 32'(instr_valid), 32'h0);
        checkOutput("jump9_pc", 32'(pc), 32'h9);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("jump9_mar", 32'(rom_input_address), 32'h9);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("jump9_ce", 32'(CE_bar), 32'h0);
        checkOutput("jump9_pcinc", 32'(pc), 32'hA);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("jump9_ir", 32'({opcode, operand}), 32'hA9);

        // Jump to 15, then the PC wraps to 0
        applyStimulus(1'b1, 1'b1, 4'hF, 1'b0);
        checkOutput("jump15_pc", 32'(pc), 32'hF);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("wrap_pc", 32'(pc), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("jump15_ir", 32'({opcode, operand}), 32'hAF);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("wrap_mar", 32'(rom_input_address), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("wrap_ir", 32'({opcode, operand}), 32'h1E);
        checkOutput("wrap_pc1", 32'(pc), 32'h1);

        // Halt wins over jump; PC frozen, ROM stays disabled
        applyStimulus(1'b1, 1'b1, 4'h5, 1'b1);
        checkOutput("halt_halted", 32'(halted), 32'h1);
        checkOutput("halt_valid", 32'(instr_valid), 32'h0);
        checkOutput("halt_pc", 32'(pc), 32'h1);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
            checkOutput($sformatf("halted_ce_%0d", c), 32'(CE_bar), 32'h1);
            checkOutput($sformatf("halted_flag_%0d", c), 32'(halted), 32'h1);
        end
        checkOutput("halted_pc_end", 32'(pc), 32'h1);

        // Reset out of HALTED clears IR asynchronously
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("halt_reset");
        tick();
        rst = 1'b0;

        // Reset pulsed in the middle of FETCH_READ
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("midread_ce_low", 32'(CE_bar), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midread");
        tick();
        checkResetValues("midread_held");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        checkOutput("after_rst_valid", 32'(instr_valid), 32'h1);
        checkOutput("after_rst_ir", 32'({opcode, operand}), 32'h1E);

`ifdef FETCH_SINGLE_STEP_EN
        // With step low nothing is fetched; one pulse fetches once
        rst = 1'b1;
        step = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
            checkOutput($sformatf("nostep_ce_%0d", c), 32'(CE_bar), 32'h1);
            checkOutput($sformatf("nostep_valid_%0d", c), 32'(instr_valid), 32'h0);
        end
        step = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        step = 1'b0;
        valid_seen = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
            if (instr_valid) valid_seen++;
        end
        checkOutput("step_valid_count", 32'(valid_seen), 32'h1);
        checkOutput("step_pc", 32'(pc), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vector_count, miscompare_count);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

SAP-1 instruction fetch stage sitting directly upstream of the 16×8 program ROM. Holds the program counter (PC) and memory address register (MAR), drives the ROM address and active-low chip enable, and captures the returned word into the instruction register (IR). It presents the opcode and operand to the execute controller with a valid/done handshake. Jump and halt requests come back from execute.

## Interface
- WordSize, 8, ROM word width / IR width
- AddressSize, 4, ROM address width; PC and MAR width
- OpcodeSize, 4, upper IR bits forming the opcode; operand = low WordSize-OpcodeSize bits
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rom_input_address  out  AddressSize  ROM address, always equal to MAR
- CE_bar  out  1  ROM chip enable, active low
- rom_output_data  in  WordSize  ROM data; valid only while CE_bar=0
- instr_valid  out  1  IR holds a fetched instruction awaiting execute
- opcode  out  OpcodeSize  IR[WordSize-1 -: OpcodeSize]
- operand  out  WordSize-OpcodeSize  IR low bits
- exec_done  in  1  execute has finished the current instruction
- jump  in  1  with exec_done: load PC from jump_address
- jump_address  in  AddressSize  jump target
- halt  in  1  with exec_done: stop fetching
- halted  out  1  unit is in HALTED
- pc  out  AddressSize  current PC, for display/debug

## Operation
- States: FETCH_ADDR, FETCH_INC, FETCH_READ, DISPATCH, HALTED.
- FETCH_ADDR: MAR <= PC. Next state is FETCH_INC.
- FETCH_INC: PC <= PC + 1, modulo 2^AddressSize (PC at max value wraps to 0). Next state is FETCH_READ.
- FETCH_READ: CE_bar=0 for the whole cycle. IR <= rom_output_data at the closing edge. Next state is DISPATCH.
- DISPATCH: instr_valid=1. Remain in DISPATCH until exec_done=1. When exec_done=1, sample the requests in this priority:
  - halt=1: go to HALTED; PC unchanged.
  - else jump=1: PC <= jump_address; go to FETCH_ADDR.
  - else: go to FETCH_ADDR.
- jump or halt asserted without exec_done is ignored.
- exec_done outside DISPATCH is ignored.
- HALTED: halted=1, CE_bar=1, instr_valid=0. Exit only through rst.
- CE_bar=1 in every state except FETCH_READ.
- IR holds its value outside FETCH_READ.

## Timing
- Reset values:
  - state = FETCH_ADDR
  - PC = 0, MAR = 0, IR = 0
  - CE_bar = 1, instr_valid = 0, halted = 0
- All outputs are registered or decoded from state only, with no input-to-output combinational path. rom_input_address = MAR.
- After reset release, the third rising edge sets instr_valid=1 with IR = rom[0].
- Minimum instruction period is 4 cycles, with exec_done=1 on the first DISPATCH cycle. instr_valid falls on the edge that samples exec_done.
- Jump latency: the edge that samples exec_done&jump loads PC. The next FETCH_READ reads rom[jump_address].
- rst asserted in any state (including mid-READ or DISPATCH) immediately forces the reset values. It drops CE_bar to 1 with no partial IR capture.

## Configuration
- FETCH_SINGLE_STEP_EN defined:
  - Adds input port step (1 bit).
  - FETCH_ADDR advances only on a cycle with step=1. Otherwise it holds with CE_bar=1.
  - One instruction is fetched per step assertion; holding step high free-runs.
- Not defined: no step port; FETCH_ADDR always advances.

## Structure
- Package sap1_fetch_pkg holds:
  - fetch_state_t enum (the five states)
  - PC_RESET constant (0)
- Sub-module program_counter: AddressSize-wide counter with async active-high reset, inc and load/load_value inputs; load has priority over inc. fetch_unit instantiates it once.
- The state machine, MAR and IR live in fetch_unit.

## Test plan
- ROM words 0x1E, 0x2F, 0xF0 at 0..2; exec_done tied 1 -> instr_valid on cycles 3, 7, 11 with opcode/operand 1/E, 2/F, F/0; CE_bar low only in cycles 2, 6, 10.
- PC preloaded by jumping to 15; continue -> the next fetch reads rom[15] and the following one reads rom[0] (wrap).
- In DISPATCH, exec_done=1 and jump=1 with jump_address=9 -> next FETCH_READ reads rom[9]; jump=1 with exec_done=0 has no effect.
- exec_done=1 with halt=1 and jump=1 -> halted=1, PC unchanged, CE_bar stays 1 for 20 cycles.
- rst pulsed during FETCH_READ -> CE_bar=1, instr_valid=0, IR=0 asynchronously; first fetch after release is rom[0].
- With FETCH_SINGLE_STEP_EN: step low for 10 cycles -> no CE_bar activity; a single step pulse -> exactly one instr_valid.
